// File: rtl/lcd_bus_reader_pkg.sv
// Shared definitions for the HD44780-style LCD bus engines (read side and write driver).
package lcd_bus_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_RECOVER,
        ST_DONE
    } lcd_rd_state_t;

    localparam int unsigned BF_BIT    = 7;
    localparam logic        RS_STATUS = 1'b0;
    localparam logic        RS_DATA   = 1'b1;

    // Bus timing defaults, in CLK cycles, shared with the write driver
    localparam int unsigned T_AS_DEF     = 1;
    localparam int unsigned T_EH_DEF     = 10;
    localparam int unsigned T_REC_DEF    = 10;
    localparam int unsigned POLL_MAX_DEF = 1000;

    // Width of the phase timer load value
    localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// Loading N-1 therefore gives a phase that lasts exactly N cycles.
module lcd_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for the 8-bit HD44780-style LCD bus: timed RW=1 cycles,
// with optional repeat of the status read until the busy flag clears.
// All bus and handshake outputs are registered from the current state, so
// they trail the state register by one cycle.
module lcd_bus_reader
    import lcd_bus_reader_pkg::*;
#(
    parameter int unsigned T_AS     = T_AS_DEF,
    parameter int unsigned T_EH     = T_EH_DEF,
    parameter int unsigned T_REC    = T_REC_DEF,
    parameter int unsigned POLL_MAX = POLL_MAX_DEF
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       busy,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_timeout,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E
);

    localparam int unsigned CW = $clog2(POLL_MAX + 1);

    lcd_rd_state_t r_state, w_next;

    logic             r_rs;
    logic             r_poll;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_sample;
    logic             w_tc;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_bus_active;

    lcd_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (RESETN),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // State register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; every state change reloads the timer for the new phase
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE:    if (rd_req) w_next = ST_SETUP;
            ST_SETUP:   if (w_tc)   w_next = ST_EHIGH;
            ST_EHIGH:   if (w_tc)   w_next = ST_HOLD;
            ST_HOLD:                w_next = ST_RECOVER;
            ST_RECOVER: begin
                if (w_tc) begin
                    if (r_poll && r_sample[BF_BIT] && (r_cnt < CW'(POLL_MAX)))
                        w_next = ST_SETUP;
                    else
                        w_next = ST_DONE;
                end
            end
            ST_DONE:                w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
        if (w_next != r_state) begin
            w_load = 1'b1;
            case (w_next)
                ST_SETUP:   w_load_val = TMR_W'(T_AS - 1);
                ST_EHIGH:   w_load_val = TMR_W'(T_EH - 1);
                ST_RECOVER: w_load_val = TMR_W'(T_REC - 1);
                default:    w_load_val = '0;
            endcase
        end
    end

    // Request latch, read counter and bus sample (taken on the last E-high cycle)
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rs     <= 1'b0;
            r_poll   <= 1'b0;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            if (r_state == ST_IDLE && rd_req) begin
                r_rs   <= rd_rs;
                r_poll <= rd_poll & (rd_rs == RS_STATUS);
                r_cnt  <= '0;
            end
            if (r_state == ST_EHIGH && w_tc) begin
                r_sample <= LCD_DATA_IN;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_EHIGH) ||
                          (r_state == ST_HOLD)  || (r_state == ST_RECOVER);

    // Registered bus and handshake outputs; busy follows the next state so it
    // drops exactly when rd_valid rises and a new request can be taken
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            LCD_E       <= 1'b0;
            LCD_RW      <= 1'b0;
            LCD_RS      <= 1'b0;
            LCD_DATA_OE <= 1'b0;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
            rd_timeout  <= 1'b0;
        end else begin
            LCD_E       <= (r_state == ST_EHIGH);
            LCD_RW      <= w_bus_active;
            LCD_RS      <= w_bus_active & r_rs;
            LCD_DATA_OE <= 1'b0;
            busy        <= (w_next != ST_IDLE);
            rd_valid    <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                rd_data    <= r_sample;
                rd_timeout <= r_poll & r_sample[BF_BIT];
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: default-parameter instance plus a
// POLL_MAX=5 instance for the poll timeout case.
module tb_lcd_bus_reader;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       req = 1'b0;
    logic       rdrs = 1'b0;
    logic       rdpoll = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sel = 1'b0;

    logic       req_a, req_b;
    logic       busy_a, valid_a, to_a, oe_a, rs_a, rw_a, e_a;
    logic       busy_b, valid_b, to_b, oe_b, rs_b, rw_b, e_b;
    logic [7:0] data_a, data_b;

    logic       w_busy, w_valid, w_to, w_oe, w_rs, w_rw, w_e;
    logic [7:0] w_data;

    int n_cmp = 0;
    int n_err = 0;

    int         t_valid_edge, t_nvalid, t_pulses, t_ehigh, t_rwcyc;
    int         t_rwbad, t_rsbad, t_oebad;
    logic       t_busy1, t_to;
    logic [7:0] t_data;

    always #5 CLK = ~CLK;

    assign req_a = req & ~sel;
    assign req_b = req & sel;

    assign w_busy  = sel ? busy_b  : busy_a;
    assign w_valid = sel ? valid_b : valid_a;
    assign w_to    = sel ? to_b    : to_a;
    assign w_oe    = sel ? oe_b    : oe_a;
    assign w_rs    = sel ? rs_b    : rs_a;
    assign w_rw    = sel ? rw_b    : rw_a;
    assign w_e     = sel ? e_b     : e_a;
    assign w_data  = sel ? data_b  : data_a;

    lcd_bus_reader dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .rd_req      (req_a),
        .rd_rs       (rdrs),
        .rd_poll     (rdpoll),
        .busy        (busy_a),
        .rd_valid    (valid_a),
        .rd_data     (data_a),
        .rd_timeout  (to_a),
        .LCD_DATA_IN (din),
        .LCD_DATA_OE (oe_a),
        .LCD_RS      (rs_a),
        .LCD_RW      (rw_a),
        .LCD_E       (e_a)
    );

    lcd_bus_reader #(
        .POLL_MAX (5)
    ) dut5 (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .rd_req      (req_b),
        .rd_rs       (rdrs),
        .rd_poll     (rdpoll),
        .busy        (busy_b),
        .rd_valid    (valid_b),
        .rd_data     (data_b),
        .rd_timeout  (to_b),
        .LCD_DATA_IN (din),
        .LCD_DATA_OE (oe_b),
        .LCD_RS      (rs_b),
        .LCD_RW      (rw_b),
        .LCD_E       (e_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request accepted at edge 0, then ncyc observed edges. The bus model
    // returns d_busy for the first n_busy E pulses and d_final afterwards.
    // rd_req is re-pulsed for one cycle after edges p1 and p2.
    task automatic run_txn(input logic s, input logic rs, input logic poll,
                           input logic [7:0] d_busy, input int n_busy,
                           input logic [7:0] d_final, input int ncyc,
                           input int p1, input int p2);
        logic prev_e;
        sel = s;
        t_valid_edge = -1; t_nvalid = 0; t_pulses = 0; t_ehigh = 0; t_rwcyc = 0;
        t_rwbad = 0; t_rsbad = 0; t_oebad = 0; t_busy1 = 1'b0; t_to = 1'bx; t_data = 8'hxx;
        din    = (n_busy > 0) ? d_busy : d_final;
        rdrs   = rs;
        rdpoll = poll;
        req    = 1'b1;
        @(posedge CLK); #1;
        prev_e = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            req = ((k - 1) == p1) || ((k - 1) == p2);
            @(posedge CLK); #1;
            if (w_e && !prev_e) begin
                t_pulses++;
                din = (t_pulses <= n_busy) ? d_busy : d_final;
            end
            if (w_e) t_ehigh++;
            if (w_e && !w_rw) t_rwbad++;
            if (w_rw) begin
                t_rwcyc++;
                if (w_rs !== rs) t_rsbad++;
            end else if (w_rs !== 1'b0) begin
                t_rsbad++;
            end
            if (w_oe !== 1'b0) t_oebad++;
            if (k == 1) t_busy1 = w_busy;
            if (w_valid) begin
                t_nvalid++;
                if (t_valid_edge < 0) begin
                    t_valid_edge = k;
                    t_data = w_data;
                    t_to = w_to;
                end
            end
            prev_e = w_e;
        end
        req = 1'b0;
    endtask

    initial begin
        // Reset state
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_E",       {31'd0, e_a},   32'd0);
        chk("rst_RW",      {31'd0, rw_a},  32'd0);
        chk("rst_RS",      {31'd0, rs_a},  32'd0);
        chk("rst_OE",      {31'd0, oe_a},  32'd0);
        chk("rst_busy",    {31'd0, busy_a}, 32'd0);
        chk("rst_valid",   {31'd0, valid_a}, 32'd0);
        chk("rst_data",    {24'd0, data_a}, 32'h00);
        chk("rst_timeout", {31'd0, to_a},  32'd0);
        #4 RESETN = 1'b1;
        @(posedge CLK); #1;

        // Single status read
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h25, 40, -10, -10);
        chk("st_valid_edge", t_valid_edge, 32'd23);
        chk("st_nvalid",     t_nvalid,     32'd1);
        chk("st_pulses",     t_pulses,     32'd1);
        chk("st_ehigh",      t_ehigh,      32'd10);
        chk("st_rw_cycles",  t_rwcyc,      32'd22);
        chk("st_rw_bad",     t_rwbad,      32'd0);
        chk("st_busy1",      {31'd0, t_busy1}, 32'd1);
        chk("st_data",       {24'd0, t_data},  32'h25);
        chk("st_timeout",    {31'd0, t_to},    32'd0);
        chk("st_rw_after",   {31'd0, w_rw},    32'd0);
        chk("st_busy_after", {31'd0, w_busy},  32'd0);

        // Data read
        run_txn(1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h41, 40, -10, -10);
        chk("dr_valid_edge", t_valid_edge, 32'd23);
        chk("dr_rs_bad",     t_rsbad,      32'd0);
        chk("dr_rs_cycles",  t_rwcyc,      32'd22);
        chk("dr_oe_bad",     t_oebad,      32'd0);
        chk("dr_data",       {24'd0, t_data}, 32'h41);
        chk("dr_rs_after",   {31'd0, w_rs},   32'd0);

        // Busy poll: BF set for three reads, then clear
        run_txn(1'b0, 1'b0, 1'b1, 8'h80, 3, 8'h07, 100, -10, -10);
        chk("poll_pulses",     t_pulses,     32'd4);
        chk("poll_valid_edge", t_valid_edge, 32'd89);
        chk("poll_rw_cycles",  t_rwcyc,      32'd88);
        chk("poll_data",       {24'd0, t_data}, 32'h07);
        chk("poll_timeout",    {31'd0, t_to},   32'd0);
        chk("poll_oe_bad",     t_oebad,      32'd0);

        // Poll timeout with POLL_MAX=5 and BF stuck high
        run_txn(1'b1, 1'b0, 1'b1, 8'hFF, 1000, 8'hFF, 125, -10, -10);
        chk("to_pulses",     t_pulses,     32'd5);
        chk("to_valid_edge", t_valid_edge, 32'd111);
        chk("to_nvalid",     t_nvalid,     32'd1);
        chk("to_data",       {24'd0, t_data}, 32'hFF);
        chk("to_timeout",    {31'd0, t_to},   32'd1);

        // Poll request with rd_rs=1 is a single data read
        run_txn(1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h80, 40, -10, -10);
        chk("rsp_pulses",  t_pulses, 32'd1);
        chk("rsp_data",    {24'd0, t_data}, 32'h80);
        chk("rsp_timeout", {31'd0, t_to},   32'd0);

        // Requests during EHIGH (after edge 5) and DONE (after edge 22) are ignored
        run_txn(1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h5A, 60, 5, 22);
        chk("rwb_nvalid",     t_nvalid,     32'd1);
        chk("rwb_pulses",     t_pulses,     32'd1);
        chk("rwb_valid_edge", t_valid_edge, 32'd23);
        chk("rwb_data",       {24'd0, t_data}, 32'h5A);

        // Reset asserted between edges while E is high
        sel = 1'b0; din = 8'h33; rdrs = 1'b0; rdpoll = 1'b0; req = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("mr_E_before", {31'd0, e_a}, 32'd1);
        #2 RESETN = 1'b0;
        #1;
        chk("mr_E",     {31'd0, e_a},    32'd0);
        chk("mr_RW",    {31'd0, rw_a},   32'd0);
        chk("mr_RS",    {31'd0, rs_a},   32'd0);
        chk("mr_busy",  {31'd0, busy_a}, 32'd0);
        chk("mr_valid", {31'd0, valid_a}, 32'd0);
        chk("mr_data",  {24'd0, data_a}, 32'h00);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        t_nvalid = 0; t_pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (valid_a) t_nvalid++;
            if (e_a) t_pulses++;
        end
        chk("mr_no_valid", t_nvalid, 32'd0);
        chk("mr_no_e",     t_pulses, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style 8-bit character LCD bus; the counterpart of the existing LCD write driver.
- Performs timed read cycles (RW=1):
  - RS=0 returns the busy flag plus address counter.
  - RS=1 returns DDRAM/CGRAM data.
- Optional poll mode repeats the status read until the busy flag clears, so the write driver can replace its fixed delays with real busy-wait.
- Sits beside the write driver. The top level muxes LCD_RS/LCD_RW/LCD_E between the two and drives the data pads from LCD_DATA_OE.

Parameters:
- T_AS, 1: CLK cycles of RS/RW setup before E rises (min 1).
- T_EH, 10: CLK cycles E is held high (min 2).
- T_REC, 10: CLK cycles E stays low after hold, before the next cycle or completion (min 1).
- POLL_MAX, 1000: maximum status reads in poll mode before timeout (min 1).

Ports:
- CLK  in  1  system clock
- RESETN  in  1  asynchronous active-low reset
- rd_req  in  1  start request; sampled only in IDLE
- rd_rs  in  1  register select for the request (0 = status, 1 = data)
- rd_poll  in  1  poll until BF=0; honoured only when rd_rs=0
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- rd_valid  out  1  one-cycle completion strobe
- rd_data  out  8  sampled bus byte; held until the next completion
- rd_timeout  out  1  valid with rd_valid; 1 = poll gave up with BF still 1
- LCD_DATA_IN  in  8  LCD data pads, input path
- LCD_DATA_OE  out  1  1 = FPGA drives the pads; this block only ever releases them (0)
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/write (1 = read)
- LCD_E  out  1  LCD enable strobe

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous on RESETN low. All outputs are registered.
- Reset values: LCD_E=0, LCD_RW=0, LCD_RS=0, LCD_DATA_OE=0, busy=0, rd_valid=0, rd_data=8'h00, rd_timeout=0. State goes to IDLE, counters to 0.
- State machine: IDLE -> SETUP -> EHIGH -> HOLD -> RECOVER -> (SETUP | DONE) -> IDLE.
- IDLE:
  - On rd_req=1, latch rd_rs, and latch poll = rd_poll & ~rd_rs.
  - Clear the read count and enter SETUP.
  - rd_req in any other state is ignored, not queued.
- SETUP: LCD_RW=1, LCD_RS=latched rs, LCD_DATA_OE=0, LCD_E=0. Lasts T_AS cycles.
- EHIGH: LCD_E=1 for T_EH cycles. LCD_DATA_IN is captured into an internal sample register on the last EHIGH cycle. The read count increments.
- HOLD: one cycle with LCD_E=0; RW and RS unchanged.
- RECOVER: T_REC cycles with E=0 and RW=1. At the end:
  - If poll=1, sample[7]=1, and read count < POLL_MAX: go to SETUP.
  - Otherwise: go to DONE.
- DONE (one cycle):
  - rd_valid=1; rd_data=sample.
  - rd_timeout = poll & sample[7].
  - LCD_RW returns to 0 and LCD_RS to 0.
  - Next state is IDLE.
- Latency:
  - A single read asserts rd_valid exactly T_AS+T_EH+T_REC+2 edges after the accepting edge (23 with defaults).
  - With n polled reads, it asserts n*(T_AS+T_EH+T_REC+1)+1 edges after acceptance.
- Simultaneous events: rd_req high during DONE is ignored. A new request is accepted in IDLE at the earliest one cycle after rd_valid.
- Reset mid-operation: LCD_E drops immediately (asynchronously) and no rd_valid is produced. RW falls before any subsequent E rise.
- rd_rs=1 with rd_poll=1: poll is ignored; a single data read is performed.
- Read count: width clog2(POLL_MAX+1); no wrap is possible.

Decomposition:
- Shared LCD package:
  - State encoding enum.
  - BF_BIT=7.
  - RS_STATUS=1'b0, RS_DATA=1'b1.
  - Timing defaults shared with the write driver.
- One sub-module, lcd_phase_timer: a loadable down-counter with a terminal-count strobe, reused for T_AS, T_EH and T_REC.

Test Plan:
- Single status read:
  - Stimulus: reset, rd_req=1 with rd_rs=0, rd_poll=0; LCD_DATA_IN=8'h25.
  - Required: E high for exactly 10 cycles, RW=1 throughout; rd_valid at edge 23; rd_data=8'h25, rd_timeout=0; RW=0 after DONE.
- Data read:
  - Stimulus: rd_rs=1, LCD_DATA_IN=8'h41.
  - Required: RS=1 during SETUP through RECOVER; rd_data=8'h41; LCD_DATA_OE=0 at all times.
- Busy poll:
  - Stimulus: rd_poll=1, rd_rs=0; model returns 8'h80 for 3 reads, then 8'h07.
  - Required: 4 E pulses; rd_valid at edge 4*22+1=89; rd_data=8'h07, rd_timeout=0.
- Timeout:
  - Stimulus: POLL_MAX=5; BF stuck at 1 (LCD_DATA_IN=8'hFF).
  - Required: exactly 5 E pulses; rd_valid with rd_timeout=1 and rd_data=8'hFF.
- Request while busy:
  - Stimulus: pulse rd_req again during EHIGH and during DONE.
  - Required: both ignored; exactly one rd_valid is produced.
- Mid-operation reset:
  - Stimulus: assert RESETN=0 during EHIGH.
  - Required: LCD_E=0 in the same cycle without waiting for a clock edge; all outputs at reset values; no rd_valid after release.
